// File: rtl/fetch_pkg.sv
// Shared core constants: phase encodings, fetch FSM states and PC defaults.
package fetch_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DONE = 2'd2
    } fetch_st_t;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: req/ack read of the word at PC during FETCH,
// single PC advance (sequential or redirect) on entry to WRITE.
module fetch #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [31:0]        instr_raw,
    output logic [31:0]        pc,
    output logic               fetch_done,
    output logic               misalign,
    output logic [31:0]        retired
);
    import fetch_pkg::*;

    fetch_st_t          fsm_q, fsm_d;
    logic [IMEM_AW-1:0] addr_q;
    logic [31:0]        instr_q, pc_q, retired_q;
    logic [2:0]         prev_state_q;
    logic               done_q, misalign_q;
    logic               issue, complete, advance;

    assign issue    = (fsm_q == F_IDLE) && (state == ST_FETCH);
    assign complete = (fsm_q == F_WAIT) && imem_ack;
    // Edge-detect so a multi-cycle WRITE phase advances the PC only once.
    assign advance  = (state == ST_WRITE) && (prev_state_q != ST_WRITE);

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= F_IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            F_IDLE:  if (state == ST_FETCH) fsm_d = F_WAIT;
            F_WAIT:  if (imem_ack)          fsm_d = F_DONE;
            F_DONE:  if (state != ST_FETCH) fsm_d = F_IDLE;
            default:                        fsm_d = F_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (fsm_q == F_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= RESET_PC[IMEM_AW+1:2];
            instr_q      <= '0;
            done_q       <= 1'b0;
            pc_q         <= RESET_PC;
            misalign_q   <= 1'b0;
            retired_q    <= '0;
            prev_state_q <= ST_FETCH;
        end else begin
            prev_state_q <= state;
            done_q       <= complete;
            // Address is captured at issue so it cannot move while WAIT holds.
            if (issue)    addr_q  <= pc_q[IMEM_AW+1:2];
            if (complete) instr_q <= imem_rdata;
            if (advance) begin
                retired_q <= retired_q + 32'd1;
                if (branch_taken) begin
                    pc_q <= {branch_target[31:2], 2'b00};
                    if (branch_target[1:0] != 2'b00) misalign_q <= 1'b1;
                end else begin
                    pc_q <= pc_q + PC_STEP;
                end
            end
        end
    end

    assign imem_addr  = addr_q;
    assign instr_raw  = instr_q;
    assign pc         = pc_q;
    assign fetch_done = done_q;
    assign misalign   = misalign_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: expected fetch results are queued at ack time and
// checked by an independent monitor whenever fetch_done pulses.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_raw;
    logic [31:0] pc;
    logic        fetch_done;
    logic        misalign;
    logic [31:0] retired;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
        .clk(clk), .rst(rst), .state(state),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_raw(instr_raw), .pc(pc), .fetch_done(fetch_done),
        .misalign(misalign), .retired(retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every fetch_done cycle pops one expected fetch result.
    always @(negedge clk) begin
        if (fetch_done === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_fetch_done: instr %h pc %h, none expected", instr_raw, pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (instr_raw !== e.instr || pc !== e.pc) begin
                    bad++;
                    $display("FAIL fetch_result: got instr %h pc %h expected instr %h pc %h",
                             instr_raw, pc, e.instr, e.pc);
                end
            end
        end
    end

    task automatic do_fetch(input int delay, input logic [31:0] data, input logic [31:0] exp_pc);
        int   n0;
        bit   seen;
        exp_t e;
        n0   = done_cnt;
        seen = 0;
        state = 3'd0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL req_timeout: imem_req never rose for pc %h", exp_pc);
        end
        chk("imem_addr", {18'h0, imem_addr}, {18'h0, exp_pc[15:2]});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("req_held", {31'h0, imem_req}, 32'd1);
            chk("addr_held", {18'h0, imem_addr}, {18'h0, exp_pc[15:2]});
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        e.instr = data;
        e.pc    = exp_pc;
        exp_q.push_back(e);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        // Stay in FETCH a bit longer: no second request may appear.
        repeat (2) begin
            @(negedge clk);
            chk("no_double_fetch", {31'h0, imem_req}, 32'd0);
        end
        chk("done_pulses", done_cnt - n0, 32'd1);
        chk("instr_hold", instr_raw, data);
        state = 3'd1;
        @(negedge clk);
    endtask

    task automatic do_write(input int cycles, input logic taken, input logic [31:0] tgt);
        branch_taken  = taken;
        branch_target = tgt;
        state = 3'd2;
        @(negedge clk);
        state = 3'd4;
        repeat (cycles) @(negedge clk);
        state = 3'd1;
        branch_taken = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; state = 3'd1; imem_ack = 1'b0; imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr_raw, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_done", {31'h0, fetch_done}, 32'd0);
        chk("rst_misalign", {31'h0, misalign}, 32'd0);
        chk("rst_retired", retired, 32'd0);

        do_fetch(1, 32'h0050_0093, 32'h0);
        chk("pc_after_fetch", pc, 32'h0);

        do_write(3, 1'b0, 32'h0);
        chk("pc_seq", pc, 32'h4);
        chk("retired_1", retired, 32'd1);

        do_fetch(5, 32'h0010_8113, 32'h4);

        do_write(2, 1'b1, 32'h0000_0102);
        chk("pc_redirect", pc, 32'h100);
        chk("misalign_set", {31'h0, misalign}, 32'd1);
        chk("retired_2", retired, 32'd2);

        do_fetch(0, 32'hFE01_0113, 32'h100);
        chk("misalign_sticky", {31'h0, misalign}, 32'd1);

        do_write(1, 1'b1, 32'hFFFF_FFFC);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        do_write(1, 1'b0, 32'h0);
        chk("pc_wrap", pc, 32'h0);
        chk("retired_4", retired, 32'd4);
        chk("misalign_still", {31'h0, misalign}, 32'd1);

        // Reset in the middle of WAIT, then a late ack.
        begin
            int  n0;
            bit  seen;
            n0 = done_cnt;
            seen = 0;
            state = 3'd0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (imem_req === 1'b1) seen = 1;
            end
            chk("rst_wait_req_seen", {31'h0, seen}, 32'd1);
            rst = 1'b1;
            state = 3'd1;
            @(negedge clk);
            chk("rst_wait_req_drop", {31'h0, imem_req}, 32'd0);
            rst = 1'b0;
            imem_ack = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_ack = 1'b0;
            repeat (2) @(negedge clk);
            chk("late_ack_req", {31'h0, imem_req}, 32'd0);
            chk("late_ack_instr", instr_raw, 32'h0);
            chk("late_ack_pc", pc, 32'h0);
            chk("late_ack_misalign", {31'h0, misalign}, 32'd0);
            chk("late_ack_retired", retired, 32'd0);
            chk("late_ack_no_done", done_cnt - n0, 32'd0);
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
